cdb_arbiter: RTL and testbench



---
 rtl/cdb_arbiter_pkg.sv | 15 +
 rtl/cdb_arbiter_rr_pick.sv | 31 +++
 rtl/cdb_arbiter.sv | 104 ++++++++++
 tb/tb_cdb_arbiter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: bus widths, the "no tag" label and packed-slice helpers.
// Queue instances and functional units import this package as well.
package cdb_arbiter_pkg;

  localparam int CDB_LABEL_W = 5;
  localparam int CDB_DATA_W  = 32;

  localparam logic [CDB_LABEL_W-1:0] NO_TAG = '0;

  // Low bit of field idx inside a bus that packs fields of width w side by side.
  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin picker: the first eligible index at or after ptr, wrapping.
module cdb_arbiter_rr_pick
  import cdb_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  eligible,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    // Walk from the farthest offset back to ptr so the nearest eligible index wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (eligible[(int'(ptr) + k) % N]) begin
        idx = PW'((int'(ptr) + k) % N);
        any = 1'b1;
      end
    end
    if (any) begin
      grant[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one round-robin winner per cycle is acknowledged combinationally
// and broadcast from registers on the following cycle.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = CDB_DATA_W,
  parameter int LABEL_W = CDB_LABEL_W,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       RST,
  input  logic                       FLUSH,
  input  logic [N_REQ-1:0]           reqValid,
  input  logic [N_REQ*LABEL_W-1:0]   reqLabel,
  input  logic [N_REQ*DATA_W-1:0]    reqData,
  output logic [N_REQ-1:0]           reqAck,
  output logic                       BCEN,
  output logic [LABEL_W-1:0]         BClabel,
  output logic [DATA_W-1:0]          BCdata,
  output logic                       errFlag,
  output logic [CNT_W-1:0]           bcCount
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [LABEL_W-1:0] label_arr [N_REQ];
  logic [DATA_W-1:0]  data_arr  [N_REQ];
  logic [N_REQ-1:0]   eligible;
  logic [N_REQ-1:0]   bad_tag;

  logic [N_REQ-1:0]   pick_grant;
  logic [PW-1:0]      pick_idx;
  logic               pick_any;
  logic               grant_ok;

  logic               bcen_q, bcen_d;
  logic [LABEL_W-1:0] label_q, label_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign label_arr[gi] = reqLabel[slice_lo(gi, LABEL_W) +: LABEL_W];
    assign data_arr[gi]  = reqData[slice_lo(gi, DATA_W) +: DATA_W];
    assign eligible[gi]  = reqValid[gi] && (label_arr[gi] != LABEL_W'(NO_TAG));
    assign bad_tag[gi]   = reqValid[gi] && (label_arr[gi] == LABEL_W'(NO_TAG));
  end

  cdb_arbiter_rr_pick #(
    .N  (N_REQ),
    .PW (PW)
  ) u_pick (
    .eligible (eligible),
    .ptr      (ptr_q),
    .grant    (pick_grant),
    .idx      (pick_idx),
    .any      (pick_any)
  );

  always_comb begin
    grant_ok = pick_any && !RST && !FLUSH;
    reqAck   = grant_ok ? pick_grant : '0;
    bcen_d   = grant_ok;
    label_d  = label_q;
    data_d   = data_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    // A tagless valid request is a producer bug; it is latched even while flushing.
    err_d    = err_q | (|bad_tag);
    if (grant_ok) begin
      label_d = label_arr[pick_idx];
      data_d  = data_arr[pick_idx];
      ptr_d   = (pick_idx == PW'(N_REQ - 1)) ? '0 : pick_idx + PW'(1);
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      bcen_q  <= 1'b0;
      label_q <= '0;
      data_q  <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      bcen_q  <= bcen_d;
      label_q <= label_d;
      data_q  <= data_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign BCEN    = bcen_q;
  assign BClabel = label_q;
  assign BCdata  = data_q;
  assign errFlag = err_q;
  assign bcCount = cnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed table-driven bench for cdb_arbiter plus a hand-written fairness run.
module tb_cdb_arbiter;

  logic         clk;
  logic         RST;
  logic         FLUSH;
  logic [3:0]   reqValid;
  logic [19:0]  reqLabel;
  logic [127:0] reqData;
  logic [3:0]   reqAck;
  logic         BCEN;
  logic [4:0]   BClabel;
  logic [31:0]  BCdata;
  logic         errFlag;
  logic [15:0]  bcCount;

  int n_tests;
  int n_fail;

  cdb_arbiter #(
    .N_REQ   (4),
    .DATA_W  (32),
    .LABEL_W (5),
    .CNT_W   (16)
  ) dut (
    .clk      (clk),
    .RST      (RST),
    .FLUSH    (FLUSH),
    .reqValid (reqValid),
    .reqLabel (reqLabel),
    .reqData  (reqData),
    .reqAck   (reqAck),
    .BCEN     (BCEN),
    .BClabel  (BClabel),
    .BCdata   (BCdata),
    .errFlag  (errFlag),
    .bcCount  (bcCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each row: inputs held for one cycle; expected values are what is seen at the
  // falling edge of that cycle (ack from this row's inputs, registers from the previous row).
  typedef struct {
    logic         rst;
    logic         flush;
    logic [3:0]   v;
    logic [19:0]  lab;
    logic [127:0] dat;
    logic [3:0]   ack;
    logic         bcen;
    logic [4:0]   bl;
    logic [31:0]  bd;
    logic         err;
    logic [15:0]  cnt;
  } vec_t;

  localparam int NV = 35;
  vec_t vec [NV];

  function automatic vec_t mk(input logic rst, input logic flush, input logic [3:0] v,
                              input int l3, input int l2, input int l1, input int l0,
                              input int d3, input int d2, input int d1, input int d0,
                              input logic [3:0] ack, input logic bcen, input int bl,
                              input int bd, input logic err, input int cnt);
    vec_t r;
    r.rst   = rst;
    r.flush = flush;
    r.v     = v;
    r.lab   = {5'(l3), 5'(l2), 5'(l1), 5'(l0)};
    r.dat   = {32'(d3), 32'(d2), 32'(d1), 32'(d0)};
    r.ack   = ack;
    r.bcen  = bcen;
    r.bl    = 5'(bl);
    r.bd    = 32'(bd);
    r.err   = err;
    r.cnt   = 16'(cnt);
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  int grants [4];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    //             rst flush v       l3 l2 l1 l0  d3  d2  d1  d0   ack     bcen bl bd   err cnt
    vec[0]  = mk(1, 0, 4'b0001,  0, 0, 0, 4,   0,  0,  0, 25,  4'b0000, 0,  0,  0,  0,  0);
    vec[1]  = mk(0, 0, 4'b0001,  0, 0, 0, 4,   0,  0,  0, 25,  4'b0001, 0,  0,  0,  0,  0);
    vec[2]  = mk(0, 0, 4'b0000,  0, 0, 0, 4,   0,  0,  0, 25,  4'b0000, 1,  4, 25,  0,  1);
    vec[3]  = mk(0, 0, 4'b0000,  0, 0, 0, 0,   0,  0,  0,  0,  4'b0000, 0,  4, 25,  0,  1);
    vec[4]  = mk(1, 0, 4'b0000,  0, 0, 0, 0,   0,  0,  0,  0,  4'b0000, 0,  4, 25,  0,  1);
    vec[5]  = mk(0, 0, 4'b1111,  4, 3, 2, 1,  13, 12, 11, 10,  4'b0001, 0,  0,  0,  0,  0);
    vec[6]  = mk(0, 0, 4'b1111,  4, 3, 2, 1,  13, 12, 11, 10,  4'b0010, 1,  1, 10,  0,  1);
    vec[7]  = mk(0, 0, 4'b1111,  4, 3, 2, 1,  13, 12, 11, 10,  4'b0100, 1,  2, 11,  0,  2);
    vec[8]  = mk(0, 0, 4'b1111,  4, 3, 2, 1,  13, 12, 11, 10,  4'b1000, 1,  3, 12,  0,  3);
    vec[9]  = mk(0, 0, 4'b1111,  4, 3, 2, 1,  13, 12, 11, 10,  4'b0001, 1,  4, 13,  0,  4);
    vec[10] = mk(0, 0, 4'b0000,  0, 0, 0, 0,   0,  0,  0,  0,  4'b0000, 1,  1, 10,  0,  5);
    vec[11] = mk(0, 0, 4'b0010,  0, 0, 7, 0,   0,  0, 77,  0,  4'b0010, 0,  1, 10,  0,  5);
    vec[12] = mk(0, 0, 4'b1001,  8, 0, 0, 6,  80,  0,  0, 60,  4'b1000, 1,  7, 77,  0,  6);
    vec[13] = mk(0, 0, 4'b0001,  8, 0, 0, 6,  80,  0,  0, 60,  4'b0001, 1,  8, 80,  0,  7);
    vec[14] = mk(0, 0, 4'b0000,  0, 0, 0, 0,   0,  0,  0,  0,  4'b0000, 1,  6, 60,  0,  8);
    vec[15] = mk(0, 0, 4'b0101,  0, 10, 0, 9,  0, 100, 0, 90,  4'b0100, 0,  6, 60,  0,  8);
    vec[16] = mk(0, 0, 4'b0001,  0, 10, 0, 9,  0, 100, 0, 90,  4'b0001, 1, 10, 100, 0,  9);
    vec[17] = mk(0, 0, 4'b0000,  0, 0, 0, 0,   0,  0,  0,  0,  4'b0000, 1,  9, 90,  0, 10);
    vec[18] = mk(0, 0, 4'b0010,  0, 0, 0, 0,   0,  0, 40,  0,  4'b0000, 0,  9, 90,  0, 10);
    vec[19] = mk(0, 0, 4'b0010,  0, 0, 0, 0,   0,  0, 40,  0,  4'b0000, 0,  9, 90,  1, 10);
    vec[20] = mk(0, 0, 4'b0000,  0, 0, 0, 0,   0,  0,  0,  0,  4'b0000, 0,  9, 90,  1, 10);
    vec[21] = mk(0, 0, 4'b0000,  0, 0, 0, 0,   0,  0,  0,  0,  4'b0000, 0,  9, 90,  1, 10);
    vec[22] = mk(0, 1, 4'b0100,  0, 5, 0, 0,   0, 55,  0,  0,  4'b0000, 0,  9, 90,  1, 10);
    vec[23] = mk(0, 0, 4'b0100,  0, 5, 0, 0,   0, 55,  0,  0,  4'b0100, 0,  9, 90,  1, 10);
    vec[24] = mk(0, 0, 4'b0000,  0, 0, 0, 0,   0,  0,  0,  0,  4'b0000, 1,  5, 55,  1, 11);
    vec[25] = mk(0, 0, 4'b0001,  0, 0, 0, 3,   0,  0,  0, 33,  4'b0001, 0,  5, 55,  1, 11);
    vec[26] = mk(1, 0, 4'b0001,  0, 0, 0, 3,   0,  0,  0, 33,  4'b0000, 1,  3, 33,  1, 12);
    vec[27] = mk(0, 0, 4'b0000,  0, 0, 0, 0,   0,  0,  0,  0,  4'b0000, 0,  0,  0,  0,  0);
    vec[28] = mk(0, 0, 4'b1010,  1, 0, 2, 0,  31,  0, 21,  0,  4'b0010, 0,  0,  0,  0,  0);
    vec[29] = mk(0, 0, 4'b1000,  1, 0, 2, 0,  31,  0, 21,  0,  4'b1000, 1,  2, 21,  0,  1);
    vec[30] = mk(0, 0, 4'b0000,  0, 0, 0, 0,   0,  0,  0,  0,  4'b0000, 1,  1, 31,  0,  2);
    vec[31] = mk(0, 0, 4'b0100,  0, 6, 0, 0,   0, 66,  0,  0,  4'b0100, 0,  1, 31,  0,  2);
    vec[32] = mk(0, 0, 4'b0100,  0, 6, 0, 0,   0, 66,  0,  0,  4'b0100, 1,  6, 66,  0,  3);
    vec[33] = mk(0, 0, 4'b0000,  0, 0, 0, 0,   0,  0,  0,  0,  4'b0000, 1,  6, 66,  0,  4);
    vec[34] = mk(0, 0, 4'b0000,  0, 0, 0, 0,   0,  0,  0,  0,  4'b0000, 0,  6, 66,  0,  4);

    RST      = 1'b1;
    FLUSH    = 1'b0;
    reqValid = '0;
    reqLabel = '0;
    reqData  = '0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      RST      = vec[i].rst;
      FLUSH    = vec[i].flush;
      reqValid = vec[i].v;
      reqLabel = vec[i].lab;
      reqData  = vec[i].dat;
      @(negedge clk);
      $display("[TB] row %0d rst=%0b flush=%0b v=%b ack=%b bcen=%0b label=%0d data=%0d err=%0b cnt=%0d",
               i, RST, FLUSH, reqValid, reqAck, BCEN, BClabel, BCdata, errFlag, bcCount);
      check($sformatf("row%0d reqAck", i),  int'(reqAck),  int'(vec[i].ack));
      check($sformatf("row%0d BCEN", i),    int'(BCEN),    int'(vec[i].bcen));
      check($sformatf("row%0d BClabel", i), int'(BClabel), int'(vec[i].bl));
      check($sformatf("row%0d BCdata", i),  int'(BCdata),  int'(vec[i].bd));
      check($sformatf("row%0d errFlag", i), int'(errFlag), int'(vec[i].err));
      check($sformatf("row%0d bcCount", i), int'(bcCount), int'(vec[i].cnt));
    end

    // Fairness: after reset, all four continuously valid for 8 cycles -> two grants each.
    @(posedge clk);
    #1;
    RST      = 1'b1;
    reqValid = '0;
    @(posedge clk);
    #1;
    RST      = 1'b0;
    reqValid = 4'b1111;
    reqLabel = {5'd4, 5'd3, 5'd2, 5'd1};
    reqData  = {32'd400, 32'd300, 32'd200, 32'd100};
    for (int k = 0; k < 4; k++) grants[k] = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      $display("[TB] fair cycle %0d ack=%b bcen=%0b label=%0d", c, reqAck, BCEN, BClabel);
      check($sformatf("fair%0d onehot", c), int'($onehot(reqAck)), 1);
      check($sformatf("fair%0d ack", c), int'(reqAck), 1 << (c % 4));
      for (int k = 0; k < 4; k++) if (reqAck[k]) grants[k]++;
      @(posedge clk);
    end
    for (int k = 0; k < 4; k++) check($sformatf("fair grants[%0d]", k), grants[k], 2);
    #1;
    reqValid = '0;
    @(negedge clk);
    check("fair final bcCount", int'(bcCount), 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
